// File: rtl/dccm_port_arb.sv
// rtl/dccm_port_arb.sv - LSU/DMA arbiter and read-tag sequencer for the single DCCM port; optional starvation guard via RV_DCCM_ARB_STARVE_EN
module dccm_port_arb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 39,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_freeze,
  input  logic              lsu_req_valid,
  input  logic              lsu_req_wr,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  output logic              lsu_stall,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rsp_data,
  input  logic              dma_req_valid,
  output logic              dma_req_ready,
  input  logic              dma_req_wr,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  output logic              dma_rsp_valid,
  output logic [DATA_W-1:0] dma_rsp_data,
  output logic              dma_starved,
  output logic              dccm_wren,
  output logic              dccm_rden,
  output logic [ADDR_W-1:0] dccm_wr_addr,
  output logic [ADDR_W-1:0] dccm_rd_addr_lo,
  output logic [ADDR_W-1:0] dccm_rd_addr_hi,
  output logic [DATA_W-1:0] dccm_wr_data,
  input  logic [DATA_W-1:0] dccm_rd_data_lo
);

  // Single-entry DMA request buffer
  logic              buf_valid;
  logic              buf_wr;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;

  // Arbitration results for the current cycle
  logic              lsu_grant;
  logic              dma_grant;
  logic              dma_accept;
  logic              starved;

  // Selected access driven onto the DCCM port
  logic              iss_valid;
  logic              iss_wr;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_wdata;

  // Read tag pipe: per stage a valid bit and an owner bit (1 = DMA)
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_dma;
  logic [RD_LAT-1:0] tag_v_d;
  logic [RD_LAT-1:0] tag_dma_d;
  logic              tag_out_v;
  logic              tag_out_dma;

  // Priority arbitration; reset masks every grant so all outputs sit at 0
  always_comb begin
    lsu_grant = 1'b0;
    dma_grant = 1'b0;
    lsu_stall = 1'b0;
    if (rst) begin
      lsu_grant = 1'b0;
    end else if (lsu_freeze) begin
      lsu_stall = lsu_req_valid;
    end else if (starved && buf_valid) begin
      dma_grant = 1'b1;
      lsu_stall = lsu_req_valid;
    end else if (lsu_req_valid) begin
      lsu_grant = 1'b1;
    end else if (buf_valid) begin
      dma_grant = 1'b1;
    end
  end

  // The buffer can take a new request whenever it is empty or draining this cycle
  assign dma_req_ready = !rst && (!buf_valid || dma_grant);
  assign dma_accept    = dma_req_valid && dma_req_ready;

  // Steer the winning requester onto the DCCM port
  always_comb begin
    iss_valid = lsu_grant || dma_grant;
    iss_wr    = 1'b0;
    iss_addr  = '0;
    iss_wdata = '0;
    if (lsu_grant) begin
      iss_wr    = lsu_req_wr;
      iss_addr  = lsu_req_addr;
      iss_wdata = lsu_req_wdata;
    end else if (dma_grant) begin
      iss_wr    = buf_wr;
      iss_addr  = buf_addr;
      iss_wdata = buf_wdata;
    end
  end

  // DCCM strobes; address/data buses are zero unless their strobe is active
  always_comb begin
    dccm_rden       = iss_valid && !iss_wr;
    dccm_wren       = iss_valid && iss_wr;
    dccm_rd_addr_lo = dccm_rden ? iss_addr : '0;
    dccm_rd_addr_hi = dccm_rden ? iss_addr : '0;
    dccm_wr_addr    = dccm_wren ? iss_addr : '0;
    dccm_wr_data    = dccm_wren ? iss_wdata : '0;
  end

  // DMA buffer: a same-cycle accept replaces the entry being granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_wr    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
    end else if (dma_accept) begin
      buf_valid <= 1'b1;
      buf_wr    <= dma_req_wr;
      buf_addr  <= dma_req_addr;
      buf_wdata <= dma_req_wdata;
    end else if (dma_grant) begin
      buf_valid <= 1'b0;
    end
  end

  // Next tag pipe contents: new issue enters stage 0, older tags shift up
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign tag_v_d   = dccm_rden;
      assign tag_dma_d = dma_grant;
    end else begin : g_latn
      assign tag_v_d   = {tag_v[RD_LAT-2:0], dccm_rden};
      assign tag_dma_d = {tag_dma[RD_LAT-2:0], dma_grant};
    end
  endgenerate

  // Tag pipe advances every cycle, freeze included; reset drops in-flight reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v   <= '0;
      tag_dma <= '0;
    end else begin
      tag_v   <= tag_v_d;
      tag_dma <= tag_dma_d;
    end
  end

  assign tag_out_v   = tag_v[RD_LAT-1];
  assign tag_out_dma = tag_dma[RD_LAT-1];

  // Route returning read data to its owner; data is zero when not valid
  always_comb begin
    lsu_rsp_valid = tag_out_v && !tag_out_dma;
    dma_rsp_valid = tag_out_v && tag_out_dma;
    lsu_rsp_data  = lsu_rsp_valid ? dccm_rd_data_lo : '0;
    dma_rsp_data  = dma_rsp_valid ? dccm_rd_data_lo : '0;
  end

`ifdef RV_DCCM_ARB_STARVE_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_d;

  // Count cycles where the buffered DMA request loses to the LSU; freeze holds the count
  always_comb begin
    starve_cnt_d = starve_cnt;
    if (dma_grant) begin
      starve_cnt_d = '0;
    end else if (buf_valid && !lsu_freeze && (starve_cnt != CNT_MAX)) begin
      starve_cnt_d = starve_cnt + 1'b1;
    end
  end

  // Counter and forced flag; forcing starts the cycle after the limit-th denial
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      starved    <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_d;
      if (dma_grant) begin
        starved <= 1'b0;
      end else if (starve_cnt_d == CNT_MAX) begin
        starved <= 1'b1;
      end
    end
  end
`else
  // Pure LSU priority: DMA is never forced
  assign starved = 1'b0;
`endif

  assign dma_starved = starved;

endmodule
